// File: rtl/com_emitter.sv
// com_emitter: copies a run of ARM instruction templates from the template ROM
// into code memory at an auto-incrementing code pointer, optionally patching
// one word with an immediate (OR) or a PC-relative branch offset.
module com_emitter #(
    parameter int ROM_AW  = 7,
    parameter int WORD_W  = 32,
    parameter int CODE_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ROM_AW-1:0]  req_base,
    input  logic [2:0]         req_len,
    input  logic [1:0]         req_pmode,
    input  logic [2:0]         req_pidx,
    input  logic [CODE_AW-1:0] req_imm,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [WORD_W-1:0]  rom_data,
    output logic               code_we,
    input  logic               code_ready,
    output logic [CODE_AW-1:0] code_addr,
    output logic [WORD_W-1:0]  code_wdata,
    input  logic               pc_load,
    input  logic [CODE_AW-1:0] pc_load_val,
    output logic [CODE_AW-1:0] cur_pc,
    output logic               done,
    output logic               err
);

    // Branch offset field below the ARM condition/opcode byte.
    localparam int OFF_W = WORD_W - 8;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state_reg, state_next;
    logic [CODE_AW-1:0] pc_reg, pc_next;
    logic [2:0]         idx_reg, idx_next;
    logic [ROM_AW-1:0]  base_reg, base_next;
    logic [2:0]         len_reg, len_next;
    logic [1:0]         pmode_reg, pmode_next;
    logic [2:0]         pidx_reg, pidx_next;
    logic [CODE_AW-1:0] imm_reg, imm_next;
    logic               err_reg, err_next;
    logic               done_reg, done_next;

    // One extra bit catches a run that walks off the end of the ROM.
    logic [ROM_AW:0]    rom_sum;
    logic               err_now;
    logic [WORD_W-1:0]  imm_word;
    logic [OFF_W-1:0]   br_off;

    assign rom_sum  = {1'b0, base_reg} + {{(ROM_AW - 2){1'b0}}, idx_reg};
    assign rom_addr = rom_sum[ROM_AW-1:0];
    assign err_now  = rom_sum[ROM_AW] || (rom_data == {WORD_W{1'b1}});

    // Immediate for OR-patching: at most the low 12 bits, zero-filled above.
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_imm
        if (gi < 12 && gi < CODE_AW) begin : g_bit
            assign imm_word[gi] = imm_reg[gi];
        end else begin : g_zero
            assign imm_word[gi] = 1'b0;
        end
    end

    // ARM branches are relative to PC+8, i.e. two words ahead of this word.
    assign br_off = OFF_W'(imm_reg) - OFF_W'(pc_reg) - OFF_W'(2);

    // Patch the current template word when it is the selected one.
    always_comb begin
        code_wdata = rom_data;
        if (idx_reg == pidx_reg) begin
            case (pmode_reg)
                2'd1:    code_wdata = rom_data | imm_word;
                2'd2:    code_wdata = {rom_data[WORD_W-1:OFF_W], br_off};
                default: code_wdata = rom_data;
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign code_addr = pc_reg;
    assign cur_pc    = pc_reg;
    assign done      = done_reg;
    assign err       = err_reg;

    // Next-state and write-offer logic.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        idx_next   = idx_reg;
        base_next  = base_reg;
        len_next   = len_reg;
        pmode_next = pmode_reg;
        pidx_next  = pidx_reg;
        imm_next   = imm_reg;
        err_next   = err_reg;
        done_next  = 1'b0;
        code_we    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pc_load) begin
                    pc_next = pc_load_val;
                end
                if (req_valid) begin
                    base_next  = req_base;
                    len_next   = req_len;
                    pmode_next = req_pmode;
                    pidx_next  = req_pidx;
                    imm_next   = req_imm;
                    idx_next   = 3'd0;
                    err_next   = 1'b0;
                    if (req_len == 3'd0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                if (err_now) begin
                    // Abandon the run; earlier words stay, pc is not rewound.
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    code_we = 1'b1;
                    if (code_ready) begin
                        pc_next  = pc_reg + CODE_AW'(1);
                        idx_next = idx_reg + 3'd1;
                        if (idx_reg == len_reg - 3'd1) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            idx_reg   <= '0;
            base_reg  <= '0;
            len_reg   <= '0;
            pmode_reg <= '0;
            pidx_reg  <= '0;
            imm_reg   <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            idx_reg   <= idx_next;
            base_reg  <= base_next;
            len_reg   <= len_next;
            pmode_reg <= pmode_next;
            pidx_reg  <= pidx_next;
            imm_reg   <= imm_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
        end
    end

endmodule
